// File: rtl/in_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : in_reg_bank
// Description : Pad-side input capture bank. A WIDTH-bit bus passes through
//               an optional per-bit synchroniser chain and an optional per-bit
//               persistence filter, then into an output register. The output
//               register supports capture-enable, synchronous clear and
//               synchronous preset. It also produces registered rise/fall
//               pulses and a capture strobe.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   dataIn   in   WIDTH  raw pad bus (asynchronous when SYNC_STAGES > 0)
//   sel      in   1      capture enable: load filtered data into dataOut
//   clr      in   1      synchronous clear of dataOut (highest priority)
//   hold     in   1      synchronous preset of dataOut to HOLD_VAL
//   dataOut  out  WIDTH  captured, filtered data
//   rise     out  WIDTH  one-cycle pulse per bit on a 0->1 change of dataOut
//   fall     out  WIDTH  one-cycle pulse per bit on a 1->0 change of dataOut
//   valid    out  1      one-cycle strobe: dataOut was loaded by sel
// ============================================================================
module in_reg_bank #(
    parameter int               WIDTH         = 8,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_CYCLES = 0,
    parameter logic [WIDTH-1:0] HOLD_VAL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             sel,
    input  logic             clr,
    input  logic             hold,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             valid
);

    logic [WIDTH-1:0] synced_w;
    logic [WIDTH-1:0] filt_w;

    // ------------------------------------------------------------------
    // Synchroniser: SYNC_STAGES flops per bit, or a straight wire.
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q[0] <= dataIn;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign synced_w = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign synced_w = dataIn;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Persistence filter: a bit is accepted only after it has differed
    // from the filtered value for FILTER_CYCLES consecutive cycles. Any
    // cycle where it agrees again restarts the count from zero.
    // ------------------------------------------------------------------
    generate
        if (FILTER_CYCLES > 0) begin : g_filt
            localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic             filt_q;
                logic             filt_d;
                logic [CNT_W-1:0] cnt_q;
                logic [CNT_W-1:0] cnt_d;

                always_comb begin
                    filt_d = filt_q;
                    cnt_d  = '0;
                    if (synced_w[i] != filt_q) begin
                        // The F-th consecutive differing cycle accepts the
                        // change; the counter is cleared, so it never wraps.
                        if (cnt_q == CNT_LAST) begin
                            filt_d = synced_w[i];
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        filt_q <= 1'b0;
                        cnt_q  <= '0;
                    end else begin
                        filt_q <= filt_d;
                        cnt_q  <= cnt_d;
                    end
                end

                assign filt_w[i] = filt_q;
            end
        end else begin : g_nofilt
            assign filt_w = synced_w;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register: clr > hold > sel > keep. Edge pulses compare the
    // next value against the current one so they line up with the new
    // dataOut regardless of what caused the load.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             valid_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (hold) begin
            data_d = HOLD_VAL;
        end else if (sel) begin
            data_d = filt_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            rise_q  <= data_d & ~data_q;
            fall_q  <= ~data_d & data_q;
            valid_q <= sel & ~clr & ~hold;
        end
    end

    assign dataOut = data_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_in_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_in_reg_bank
// Description : Directed bench for in_reg_bank. One instance uses
//               SYNC_STAGES=2 / FILTER_CYCLES=3, a second uses the full
//               bypass configuration. Expected outputs are queued before each
//               clock edge and compared just after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_in_reg_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] dataIn;
    logic       sel;
    logic       clr;
    logic       hold;
    logic [7:0] dataOut;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       valid;

    logic [7:0] b_dataIn;
    logic       b_sel;
    logic [7:0] b_dataOut;
    logic [7:0] b_rise;
    logic [7:0] b_fall;
    logic       b_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    in_reg_bank #(
        .WIDTH         (8),
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dataIn  (dataIn),
        .sel     (sel),
        .clr     (clr),
        .hold    (hold),
        .dataOut (dataOut),
        .rise    (rise),
        .fall    (fall),
        .valid   (valid)
    );

    in_reg_bank #(
        .WIDTH         (8),
        .SYNC_STAGES   (0),
        .FILTER_CYCLES (0)
    ) dut_byp (
        .clk     (clk),
        .rst_n   (rst_n),
        .dataIn  (b_dataIn),
        .sel     (b_sel),
        .clr     (1'b0),
        .hold    (1'b0),
        .dataOut (b_dataOut),
        .rise    (b_rise),
        .fall    (b_fall),
        .valid   (b_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         byp;
        logic [7:0] d;
        logic [7:0] r;
        logic [7:0] f;
        logic       v;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input string fld,
                       input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit byp,
                              input logic [7:0] d, input logic [7:0] r,
                              input logic [7:0] f, input logic v);
        exp_t e;
        e.tag = tag;
        e.byp = byp;
        e.d   = d;
        e.r   = r;
        e.f   = f;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Advance one edge, then retire every expectation queued for it.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.byp) begin
                chk(e.tag, "dataOut", b_dataOut, e.d);
                chk(e.tag, "rise",    b_rise,    e.r);
                chk(e.tag, "fall",    b_fall,    e.f);
                chk(e.tag, "valid",   {7'd0, b_valid}, {7'd0, e.v});
            end else begin
                chk(e.tag, "dataOut", dataOut, e.d);
                chk(e.tag, "rise",    rise,    e.r);
                chk(e.tag, "fall",    fall,    e.f);
                chk(e.tag, "valid",   {7'd0, valid}, {7'd0, e.v});
            end
        end
    endtask

    task automatic run(input string tag, input int n,
                       input logic [7:0] d, input logic [7:0] r,
                       input logic [7:0] f, input logic v);
        for (int k = 0; k < n; k++) begin
            expect_out(tag, 1'b0, d, r, f, v);
            tick();
        end
    endtask

    initial begin
        dataIn   = 8'h00;
        sel      = 1'b0;
        clr      = 1'b0;
        hold     = 1'b0;
        b_dataIn = 8'h00;
        b_sel    = 1'b0;
        rst_n    = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("reset", "dataOut", dataOut, 8'h00);
        chk("reset", "rise",    rise,    8'h00);
        chk("reset", "fall",    fall,    8'h00);
        chk("reset", "valid",   {7'd0, valid}, 8'h00);
        run("reset_edge", 2, 8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        sel   = 1'b1;
        run("idle", 3, 8'h00, 8'h00, 8'h00, 1'b1);

        // Latency 2 + 3 + 1 = 6 edges, rising edges
        dataIn = 8'h0F;
        run("lat_wait", 5, 8'h00, 8'h00, 8'h00, 1'b1);
        run("lat_edge", 1, 8'h0F, 8'h0F, 8'h00, 1'b1);
        run("lat_hold", 2, 8'h0F, 8'h00, 8'h00, 1'b1);

        // Falling edges
        dataIn = 8'h00;
        run("fall_wait", 5, 8'h0F, 8'h00, 8'h00, 1'b1);
        run("fall_edge", 1, 8'h00, 8'h00, 8'h0F, 1'b1);
        run("fall_hold", 1, 8'h00, 8'h00, 8'h00, 1'b1);

        // Glitch rejection: 2-cycle pulse on bit 0 must never appear
        dataIn = 8'h01;
        run("gl2_pulse", 2, 8'h00, 8'h00, 8'h00, 1'b1);
        dataIn = 8'h00;
        run("gl2_reject", 8, 8'h00, 8'h00, 8'h00, 1'b1);

        // 3-cycle pulse is accepted; its trailing edge lands 6 edges later
        dataIn = 8'h01;
        run("gl3_pulse", 3, 8'h00, 8'h00, 8'h00, 1'b1);
        dataIn = 8'h00;
        run("gl3_wait",  2, 8'h00, 8'h00, 8'h00, 1'b1);
        run("gl3_rise",  1, 8'h01, 8'h01, 8'h00, 1'b1);
        run("gl3_high",  2, 8'h01, 8'h00, 8'h00, 1'b1);
        run("gl3_fall",  1, 8'h00, 8'h00, 8'h01, 1'b1);
        run("gl3_low",   1, 8'h00, 8'h00, 8'h00, 1'b1);

        // Priority: clr beats hold beats sel
        dataIn = 8'h55;
        run("prio_load_wait", 5, 8'h00, 8'h00, 8'h00, 1'b1);
        run("prio_load",      1, 8'h55, 8'h55, 8'h00, 1'b1);
        clr  = 1'b1;
        hold = 1'b1;
        run("prio_all", 1, 8'h00, 8'h00, 8'h55, 1'b0);
        clr = 1'b0;
        sel = 1'b0;
        run("prio_hold", 1, 8'hFF, 8'hFF, 8'h00, 1'b0);
        hold = 1'b0;
        run("prio_idle", 1, 8'hFF, 8'h00, 8'h00, 1'b0);

        // Enable freeze: toggling input never reaches dataOut with sel=0
        for (int i = 0; i < 20; i++) begin
            dataIn = ((i % 2) == 1) ? 8'hFF : 8'h00;
            run("freeze", 1, 8'hFF, 8'h00, 8'h00, 1'b0);
        end
        // Filter never saw a persistent change, so it still holds 0x55
        dataIn = 8'h55;
        sel    = 1'b1;
        run("unfreeze",      1, 8'h55, 8'h00, 8'hAA, 1'b1);
        run("unfreeze_hold", 2, 8'h55, 8'h00, 8'h00, 1'b1);

        // Reset mid-operation with the filter part-way through a count
        dataIn = 8'hA5;
        run("pre_rst_wait", 5, 8'h55, 8'h00, 8'h00, 1'b1);
        run("pre_rst_load", 1, 8'hA5, 8'hA0, 8'h50, 1'b1);
        dataIn = 8'h5A;
        run("midcount", 3, 8'hA5, 8'h00, 8'h00, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", "dataOut", dataOut, 8'h00);
        chk("async_rst", "rise",    rise,    8'h00);
        chk("async_rst", "fall",    fall,    8'h00);
        chk("async_rst", "valid",   {7'd0, valid}, 8'h00);
        run("rst_held", 1, 8'h00, 8'h00, 8'h00, 1'b0);
        rst_n  = 1'b1;
        dataIn = 8'h3C;
        run("post_rst_wait", 5, 8'h00, 8'h00, 8'h00, 1'b1);
        run("post_rst_load", 1, 8'h3C, 8'h3C, 8'h00, 1'b1);

        // Bypass configuration: one-edge latency, glitches pass through
        b_dataIn = 8'h81;
        b_sel    = 1'b1;
        expect_out("byp_load", 1'b1, 8'h81, 8'h81, 8'h00, 1'b1);
        tick();
        b_dataIn = 8'h83;
        expect_out("byp_glitch", 1'b1, 8'h83, 8'h02, 8'h00, 1'b1);
        tick();
        b_dataIn = 8'h81;
        expect_out("byp_back", 1'b1, 8'h81, 8'h00, 8'h02, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
